// File: rtl/rs_frame_sequencer_if.sv
// Handshake/status bundle between the RS(255,239) frame sequencer and the
// rest of the decoder bench.
//   locked          clock-source lock (input to sequencer)
//   run_req         run start pulse
//   abort           synchronous abort back to idle
//   dec_frame_done  one-cycle pulse per frame leaving the decoder
//   gen_start       symbol generator enable
//   sym_idx         current symbol index (1..N while running, else 0)
//   data_phase      payload slot indicator
//   sof             start-of-frame strobe
//   frames_issued   frames fully issued this run
//   outstanding     frames issued but not yet completed
//   busy/done/err   run status, err_code gives the error cause
// master: the sequencer side; slave: the environment driving the inputs.
interface rs_frame_sequencer_if;
  logic        locked;
  logic        run_req;
  logic        abort;
  logic        dec_frame_done;
  logic        gen_start;
  logic [7:0]  sym_idx;
  logic        data_phase;
  logic        sof;
  logic [15:0] frames_issued;
  logic [3:0]  outstanding;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  err_code;

  modport master (
    input  locked, run_req, abort, dec_frame_done,
    output gen_start, sym_idx, data_phase, sof, frames_issued, outstanding,
           busy, done, err, err_code
  );

  modport slave (
    output locked, run_req, abort, dec_frame_done,
    input  gen_start, sym_idx, data_phase, sof, frames_issued, outstanding,
           busy, done, err, err_code
  );
endinterface

// File: rtl/rs_frame_sequencer.sv
// Run-level controller for the RS(255,239) decoder bench. After a run request
// with the clock source locked, it waits LOCK_WAIT settle cycles, then issues
// NUM_FRAMES frames of N symbols each, holding off (STALL) while
// MAX_OUTSTANDING frames sit inside the decoder, and finally drains the
// decoder. Ends in DONE, or in ERR with a cause code (1 timeout, 2 lock lost,
// 3 spurious completion).
// Ports:
//   clk_in     single rising-edge clock
//   sys_rst_n  asynchronous active-low reset
//   bus        rs_frame_sequencer_if.master (inputs and status outputs)
module rs_frame_sequencer #(
  parameter int unsigned N               = 255,
  parameter int unsigned K               = 239,
  parameter int unsigned NUM_FRAMES      = 64,
  parameter int unsigned LOCK_WAIT       = 16,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned TIMEOUT         = 1024
) (
  input  logic                    clk_in,
  input  logic                    sys_rst_n,
  rs_frame_sequencer_if.master    bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOCK_WAIT, S_RUN, S_STALL, S_DRAIN, S_DONE, S_ERR
  } state_t;

  state_t      state, state_n;
  logic [7:0]  sym, sym_n;
  logic [15:0] issued, issued_n;
  logic [15:0] cnt, cnt_n;       // settle counter in LOCK_WAIT, quiet counter in STALL/DRAIN
  logic [3:0]  outst, outst_n;
  logic [1:0]  code, code_n;
  logic        gen_start_r, data_phase_r, sof_r, busy_r, done_r, err_r;
  logic        active, lock_lost, spurious, timed_out;
  logic [3:0]  out_after;        // outstanding after this cycle's completion, if any

  always_comb begin
    state_n   = state;
    sym_n     = sym;
    issued_n  = issued;
    cnt_n     = cnt;
    outst_n   = outst;
    code_n    = code;
    active    = (state == S_LOCK_WAIT) || (state == S_RUN) ||
                (state == S_STALL) || (state == S_DRAIN);
    lock_lost = active && !bus.locked;
    spurious  = bus.dec_frame_done && (outst == 4'd0) && (state != S_IDLE);
    // A completion in the same cycle resets the quiet counter, so it rescues a timeout.
    timed_out = ((state == S_STALL) || (state == S_DRAIN)) && !bus.dec_frame_done &&
                (cnt == 16'(TIMEOUT - 1));
    out_after = outst - {3'b000, bus.dec_frame_done};

    if (bus.abort) begin
      state_n = S_IDLE;
      sym_n   = 8'd0;
    end else if (lock_lost) begin
      state_n = S_ERR;
      sym_n   = 8'd0;
      code_n  = 2'd2;
    end else if (spurious) begin
      state_n = S_ERR;
      sym_n   = 8'd0;
      code_n  = 2'd3;
    end else if (timed_out) begin
      state_n = S_ERR;
      sym_n   = 8'd0;
      code_n  = 2'd1;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (bus.run_req && bus.locked) begin
            state_n  = S_LOCK_WAIT;
            issued_n = 16'd0;
            outst_n  = 4'd0;
            code_n   = 2'd0;
            cnt_n    = 16'd0;
          end
        end
        S_LOCK_WAIT: begin
          if (cnt == 16'(LOCK_WAIT - 1)) begin
            state_n = S_RUN;
            sym_n   = 8'd1;
            cnt_n   = 16'd0;
          end else begin
            cnt_n = cnt + 16'd1;
          end
        end
        S_RUN: begin
          outst_n = out_after;
          if (sym == 8'(N)) begin
            issued_n = issued + 16'd1;
            // The frame just finished enters the decoder; a simultaneous
            // completion cancels it out.
            outst_n  = out_after + 4'd1;
            if (issued_n == 16'(NUM_FRAMES)) begin
              state_n = S_DRAIN;
              sym_n   = 8'd0;
              cnt_n   = 16'd0;
            end else if (outst_n >= 4'(MAX_OUTSTANDING)) begin
              state_n = S_STALL;
              sym_n   = 8'd0;
              cnt_n   = 16'd0;
            end else begin
              sym_n = 8'd1;
            end
          end else begin
            sym_n = sym + 8'd1;
          end
        end
        S_STALL: begin
          if (bus.dec_frame_done) begin
            outst_n = out_after;
            state_n = S_RUN;
            sym_n   = 8'd1;
            cnt_n   = 16'd0;
          end else begin
            cnt_n = cnt + 16'd1;
          end
        end
        S_DRAIN: begin
          outst_n = out_after;
          cnt_n   = bus.dec_frame_done ? 16'd0 : cnt + 16'd1;
          if (out_after == 4'd0) begin
            state_n = S_DONE;
            cnt_n   = 16'd0;
          end
        end
        default: begin
          state_n = S_IDLE;
          sym_n   = 8'd0;
        end
      endcase
    end
  end

  // Status outputs are decoded from the next state so they line up with it.
  always_ff @(posedge clk_in or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state        <= S_IDLE;
      sym          <= 8'd0;
      issued       <= 16'd0;
      cnt          <= 16'd0;
      outst        <= 4'd0;
      code         <= 2'd0;
      gen_start_r  <= 1'b0;
      data_phase_r <= 1'b0;
      sof_r        <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      state        <= state_n;
      sym          <= sym_n;
      issued       <= issued_n;
      cnt          <= cnt_n;
      outst        <= outst_n;
      code         <= code_n;
      gen_start_r  <= (state_n == S_RUN);
      data_phase_r <= (state_n == S_RUN) && (sym_n <= 8'(K));
      sof_r        <= (state_n == S_RUN) && (sym_n == 8'd1);
      busy_r       <= (state_n == S_LOCK_WAIT) || (state_n == S_RUN) ||
                      (state_n == S_STALL) || (state_n == S_DRAIN);
      done_r       <= (state_n == S_DONE);
      err_r        <= (state_n == S_ERR);
    end
  end

  assign bus.gen_start     = gen_start_r;
  assign bus.sym_idx       = sym;
  assign bus.data_phase    = data_phase_r;
  assign bus.sof           = sof_r;
  assign bus.frames_issued = issued;
  assign bus.outstanding   = outst;
  assign bus.busy          = busy_r;
  assign bus.done          = done_r;
  assign bus.err           = err_r;
  assign bus.err_code      = code;

endmodule

// File: tb/tb_rs_frame_sequencer.sv
// Self-checking bench for rs_frame_sequencer: directed scenarios with
// hand-derived cycle expectations, then randomized stimulus compared every
// cycle against a behavioural model of the run/frame rules.
module tb_rs_frame_sequencer;
  localparam int N          = 255;
  localparam int K          = 239;
  localparam int NUM_FRAMES = 3;
  localparam int LOCK_WAIT  = 16;
  localparam int MAX_OUT    = 2;
  localparam int TIMEOUT    = 1024;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rs_frame_sequencer_if bus ();

  rs_frame_sequencer #(
    .N(N), .K(K), .NUM_FRAMES(NUM_FRAMES), .LOCK_WAIT(LOCK_WAIT),
    .MAX_OUTSTANDING(MAX_OUT), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_in(clk),
    .sys_rst_n(rst_n),
    .bus(bus)
  );

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  typedef enum int {M_IDLE, M_WAIT, M_RUN, M_STALL, M_DRAIN, M_DONE, M_ERR} mph_t;
  mph_t mph;
  int mpos, mwait, mquiet, miss, mout, mcode;

  function automatic void model_reset();
    mph = M_IDLE; mpos = 0; mwait = 0; mquiet = 0; miss = 0; mout = 0; mcode = 0;
  endfunction

  function automatic void model_step(bit lk, bit rq, bit ab, bit dn);
    bit running = (mph == M_WAIT) || (mph == M_RUN) || (mph == M_STALL) || (mph == M_DRAIN);
    if (ab) begin mph = M_IDLE; return; end
    if (running && !lk) begin mph = M_ERR; mcode = 2; return; end
    if (dn && mph != M_IDLE && mout == 0) begin mph = M_ERR; mcode = 3; return; end
    if ((mph == M_STALL || mph == M_DRAIN) && !dn && mquiet + 1 >= TIMEOUT) begin
      mph = M_ERR; mcode = 1; return;
    end
    case (mph)
      M_IDLE, M_DONE, M_ERR:
        if (rq && lk) begin mph = M_WAIT; mwait = 0; miss = 0; mout = 0; mcode = 0; end
      M_WAIT: begin
        mwait++;
        if (mwait == LOCK_WAIT) begin mph = M_RUN; mpos = 1; end
      end
      M_RUN: begin
        if (dn) mout--;
        if (mpos == N) begin
          miss++; mout++;
          if (miss == NUM_FRAMES) begin mph = M_DRAIN; mquiet = 0; end
          else if (mout >= MAX_OUT) begin mph = M_STALL; mquiet = 0; end
          else mpos = 1;
        end else mpos++;
      end
      M_STALL:
        if (dn) begin mout--; mph = M_RUN; mpos = 1; end
        else mquiet++;
      M_DRAIN: begin
        if (dn) begin mout--; mquiet = 0; end else mquiet++;
        if (mout == 0) mph = M_DONE;
      end
      default: ;
    endcase
  endfunction

  task automatic compare_all();
    bit r = (mph == M_RUN);
    chk("gen_start", int'(bus.gen_start), int'(r));
    chk("sym_idx", int'(bus.sym_idx), r ? mpos : 0);
    chk("data_phase", int'(bus.data_phase), int'(r && mpos <= K));
    chk("sof", int'(bus.sof), int'(r && mpos == 1));
    chk("frames_issued", int'(bus.frames_issued), miss);
    chk("outstanding", int'(bus.outstanding), mout);
    chk("busy", int'(bus.busy), int'(mph == M_WAIT || r || mph == M_STALL || mph == M_DRAIN));
    chk("done", int'(bus.done), int'(mph == M_DONE));
    chk("err", int'(bus.err), int'(mph == M_ERR));
    chk("err_code", int'(bus.err_code), mcode);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step(bus.locked, bus.run_req, bus.abort, bus.dec_frame_done);
    cyc++;
    #1;
    compare_all();
  endtask

  task automatic run_until(input int target);
    while (cyc < target) tick();
  endtask

  task automatic start_run();
    bus.run_req = 1'b1;
    tick();
    bus.run_req = 1'b0;
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_gen_start"}, int'(bus.gen_start), 0);
    chk({pfx, "_sym_idx"}, int'(bus.sym_idx), 0);
    chk({pfx, "_data_phase"}, int'(bus.data_phase), 0);
    chk({pfx, "_sof"}, int'(bus.sof), 0);
    chk({pfx, "_frames_issued"}, int'(bus.frames_issued), 0);
    chk({pfx, "_outstanding"}, int'(bus.outstanding), 0);
    chk({pfx, "_busy"}, int'(bus.busy), 0);
    chk({pfx, "_done"}, int'(bus.done), 0);
    chk({pfx, "_err"}, int'(bus.err), 0);
    chk({pfx, "_err_code"}, int'(bus.err_code), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0;
    int dp_cnt;
    int p_done;
    int ptab[4];
    int sofs[$];
    int due[$];
    ptab = '{0, 3, 20, 200};

    bus.locked = 1'b1; bus.run_req = 1'b0; bus.abort = 1'b0; bus.dec_frame_done = 1'b0;
    model_reset();
    repeat (3) tick();
    chk_all_zero("rst");
    rst_n = 1'b1;
    tick();

    // nominal: completion 300 cycles after each sof
    t0 = cyc;
    start_run();
    chk("nom_busy", int'(bus.busy), 1);
    dp_cnt = 0;
    for (int i = 0; i < 3000 && !bus.done; i++) begin
      bus.dec_frame_done = (due.size() > 0 && due[0] == cyc);
      if (bus.dec_frame_done) void'(due.pop_front());
      tick();
      if (bus.sof) begin sofs.push_back(cyc); due.push_back(cyc + 300); end
      if (bus.data_phase) dp_cnt++;
    end
    bus.dec_frame_done = 1'b0;
    chk("nom_sof_count", sofs.size(), 3);
    chk("nom_first_sof", sofs.size() > 0 ? sofs[0] - t0 : -1, 1 + LOCK_WAIT);
    chk("nom_sof_gap1", sofs.size() > 1 ? sofs[1] - sofs[0] : -1, 255);
    chk("nom_sof_gap2", sofs.size() > 2 ? sofs[2] - sofs[1] : -1, 255);
    chk("nom_data_cycles", dp_cnt, 3 * 239);
    chk("nom_done", int'(bus.done), 1);
    chk("nom_issued", int'(bus.frames_issued), 3);
    chk("nom_outstanding", int'(bus.outstanding), 0);

    // backpressure: stall after two frames, completion at t0+1000
    t0 = cyc;
    start_run();
    run_until(t0 + 527);
    chk("bp_stall_gen", int'(bus.gen_start), 0);
    chk("bp_stall_busy", int'(bus.busy), 1);
    chk("bp_stall_out", int'(bus.outstanding), 2);
    run_until(t0 + 1000);
    bus.dec_frame_done = 1'b1;
    tick();
    bus.dec_frame_done = 1'b0;
    chk("bp_resume_sof", int'(bus.sof), 1);
    chk("bp_resume_out", int'(bus.outstanding), 1);

    // timeout: no completions in DRAIN (entered at t0+1256)
    run_until(t0 + 1256);
    chk("to_drain_gen", int'(bus.gen_start), 0);
    chk("to_drain_issued", int'(bus.frames_issued), 3);
    run_until(t0 + 1256 + TIMEOUT - 1);
    chk("to_early_err", int'(bus.err), 0);
    tick();
    chk("to_err", int'(bus.err), 1);
    chk("to_code", int'(bus.err_code), 1);

    // completion coinciding with sym_idx==N at outstanding=1
    t0 = cyc;
    start_run();
    run_until(t0 + 526);
    chk("sim_sym_n", int'(bus.sym_idx), 255);
    chk("sim_out_before", int'(bus.outstanding), 1);
    bus.dec_frame_done = 1'b1;
    tick();
    bus.dec_frame_done = 1'b0;
    chk("sim_out_after", int'(bus.outstanding), 1);
    chk("sim_sof", int'(bus.sof), 1);
    chk("sim_issued", int'(bus.frames_issued), 2);

    // abort mid-RUN then clean restart
    run_until(t0 + 600);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_gen", int'(bus.gen_start), 0);
    t0 = cyc;
    start_run();
    chk("restart_issued", int'(bus.frames_issued), 0);
    chk("restart_busy", int'(bus.busy), 1);

    // lock lost at sym_idx=100
    run_until(t0 + 1 + LOCK_WAIT + 99);
    chk("ll_sym", int'(bus.sym_idx), 100);
    bus.locked = 1'b0;
    tick();
    bus.locked = 1'b1;
    chk("ll_err", int'(bus.err), 1);
    chk("ll_code", int'(bus.err_code), 2);
    chk("ll_gen", int'(bus.gen_start), 0);

    // spurious completion with nothing outstanding
    start_run();
    tick();
    bus.dec_frame_done = 1'b1;
    tick();
    bus.dec_frame_done = 1'b0;
    chk("sp_err", int'(bus.err), 1);
    chk("sp_code", int'(bus.err_code), 3);
    chk("sp_out", int'(bus.outstanding), 0);

    // asynchronous reset in the middle of STALL
    t0 = cyc;
    start_run();
    run_until(t0 + 560);
    chk("ar_in_stall", int'(bus.busy && !bus.gen_start), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("arst");
    model_reset();
    tick();
    rst_n = 1'b1;
    tick();

    // randomized traffic against the model
    p_done = 20;
    for (int i = 0; i < 30000; i++) begin
      bit idle_like;
      idle_like = (mph == M_IDLE || mph == M_DONE || mph == M_ERR);
      bus.run_req = idle_like ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 199) == 0);
      if (idle_like && bus.run_req) p_done = ptab[$urandom_range(0, 3)];
      bus.dec_frame_done = (mout > 0 && $urandom_range(0, 999) < p_done) ||
                           ($urandom_range(0, 4999) == 0);
      bus.locked = ($urandom_range(0, 19999) != 0);
      bus.abort = ($urandom_range(0, 19999) == 0);
      tick();
    end
    bus.run_req = 1'b0; bus.dec_frame_done = 1'b0; bus.abort = 1'b0; bus.locked = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
